read_pointer_control: RTL

Read-side pointer controller for the PHY receive elastic buffer. It runs in the recovered/local read clock domain and produces the binary read address and Gray-coded read pointer. It detects empty/underflow against the write-side Gray pointer and performs SKP ordered-set symbol insertion (clock-compensation "add") on request. It is the companion of the write pointer controller that performs SKP deletion and full detection.

---
 rtl/read_pointer_control.sv | 109 ++++++++++
 1 files changed

// File: rtl/read_pointer_control.sv
// Read-side pointer controller for the PHY receive elastic buffer: binary/Gray read
// pointer, empty/underflow detection and SKP insertion. Optional macro: READ_PTR_SYNC_EN.
module read_pointer_control #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 16,
    localparam int AW = $clog2(BUFFER_DEPTH)
) (
    input  logic                  read_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [AW:0]           gray_write_pointer,
    input  logic                  add_req,
    output logic                  underflow,
    output logic                  Skp_Added,
    output logic [AW:0]           read_address,
    output logic [AW:0]           gray_read_pointer,
    output logic [AW:0]           fill_level
);

    localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b0011111001);
    localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b1100000110);
    localparam logic [AW:0]           PTR_ONE = (AW + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [AW:0] read_address_q, read_address_d;
    logic        skp_added_q, skp_added_d;

    logic [AW:0] wr_gray_s;
    logic [AW:0] wr_bin;
    logic        empty;
    logic        is_skp;

`ifdef READ_PTR_SYNC_EN
    logic [AW:0] wr_sync1_q, wr_sync2_q;

    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync1_q <= '0;
            wr_sync2_q <= '0;
        end else begin
            wr_sync1_q <= gray_write_pointer;
            wr_sync2_q <= wr_sync1_q;
        end
    end

    assign wr_gray_s = wr_sync2_q;
`else
    assign wr_gray_s = gray_write_pointer;
`endif

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            wr_bin[i] = ^(wr_gray_s >> i);
        end
    end

    assign gray_read_pointer = read_address_q ^ (read_address_q >> 1);
    assign empty             = (gray_read_pointer == wr_gray_s);
    assign underflow         = empty & rst_n;
    assign fill_level        = wr_bin - read_address_q;
    assign is_skp            = (data_in == SKP_NEG) || (data_in == SKP_POS);

    always_comb begin
        state_d        = state_q;
        read_address_d = read_address_q;
        skp_added_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (add_req && is_skp) begin
                        skp_added_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        read_address_d = read_address_q + PTR_ONE;
                    end
                end
            end
            // The held SKP is still stored, so advancing here can never overrun.
            HOLD: begin
                read_address_d = read_address_q + PTR_ONE;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            read_address_q <= '0;
            skp_added_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_address_q <= read_address_d;
            skp_added_q    <= skp_added_d;
        end
    end

    assign read_address = read_address_q;
    assign Skp_Added    = skp_added_q;

endmodule
